// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM states, the
// unconditional-branch opcode, instruction size and the halt sentinel word.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [5:0]  OPC_B       = 6'b000101;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] HALT_WORD   = 32'h0;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: the aligned redirect target when a redirect
// is present, otherwise the sequential PC (or, with FETCH_BRANCH_PREDECODE_EN
// defined, the target of an unconditional B decoded from the fetched word).
// Optional feature macro: FETCH_BRANCH_PREDECODE_EN.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc;

`ifdef FETCH_BRANCH_PREDECODE_EN
  logic [PC_W-1:0] b_offset;

  // Word offset of B, sign-extended and scaled to bytes.
  assign b_offset = {{(PC_W-28){instr[25]}}, instr[25:0], 2'b00};
`else
  logic unused_instr;

  // The fetched word only matters for branch predecode.
  assign unused_instr = ^instr;
`endif

  // Redirect beats everything; low address bits of the target are dropped.
  always_comb begin
    seq_pc = pc + PC_W'(INSTR_BYTES);
`ifdef FETCH_BRANCH_PREDECODE_EN
    if (instr[31:26] == OPC_B) begin
      seq_pc = pc + b_offset;
    end
`endif
    next_pc = redirect_valid ? (redirect_target & ~PC_W'(3)) : seq_pc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and holds fetched words in a valid/ready IF/ID register toward decode.
// Redirects from execute flush the register and reload the PC; a zero word or
// a PC past the end of memory halts fetch until the next redirect.
// Optional feature macro: FETCH_BRANCH_PREDECODE_EN (handled in fetch_next_pc).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W       = 64,
  parameter int              IMEM_BYTES = 64,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic            halt
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] next_pc;
  logic            slot_free;
  logic            stop;
  logic            fire;
  logic            take_redirect;

  assign imem_addr = pc;
  assign halt      = (state == HALT);
  assign slot_free = !out_valid || out_ready;
  assign stop      = (pc > PC_W'(IMEM_BYTES - 4)) || (imem_instr == HALT_WORD);

  fetch_next_pc #(
    .PC_W(PC_W)
  ) u_next_pc (
    .pc              (pc),
    .instr           (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .next_pc         (next_pc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus fetch/redirect strobes; redirect outranks fetch and stop,
  // and is ignored while IDLE.
  always_comb begin
    state_nxt     = state;
    fire          = 1'b0;
    take_redirect = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          take_redirect = 1'b1;
        end else if (slot_free) begin
          if (stop) begin
            state_nxt = HALT;
          end else begin
            fire = 1'b1;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          take_redirect = 1'b1;
          state_nxt     = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // PC advances only on a fetch or a redirect, so stalls and halt freeze it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (take_redirect || fire) begin
      pc <= next_pc;
    end
  end

  // IF/ID register: squash on redirect, capture on fire, drain on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      if (take_redirect) begin
        out_valid <= 1'b0;
      end else if (fire) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (fire) begin
        out_instr <= imem_instr;
        out_pc    <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 16-word instruction ROM.
module tb_fetch_unit;

  localparam int PC_W = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic            halt;

  logic [31:0] mem [16];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 64) ? mem[imem_addr[5:2]] : 32'h0;

  fetch_unit #(
    .PC_W(PC_W), .IMEM_BYTES(64), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt(halt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b want 0", halt); end
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_checks++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle();
    redirect_valid = 1'b1; redirect_target = 64'h20;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL idle_redirect_ignored: got %h want 0", imem_addr); end
  endtask

  task automatic test_fetch();
    out_ready = 1'b1;
    start = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h20;
    tick();
    start = 1'b0; redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL start_no_fetch: got %b want 0", out_valid); end
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL start_beats_redirect: got %h want 0", imem_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL first_pc: got %h want 0", out_pc); end
    n_checks++; if (out_instr !== 32'hF8400142) begin n_fail++; $display("FAIL first_instr: got %h want f8400142", out_instr); end
    tick();
    n_checks++; if (out_pc !== 64'h4) begin n_fail++; $display("FAIL second_pc: got %h want 4", out_pc); end
    n_checks++; if (out_instr !== 32'hF8401143) begin n_fail++; $display("FAIL second_instr: got %h want f8401143", out_instr); end
    n_checks++; if (imem_addr !== 64'h8) begin n_fail++; $display("FAIL second_addr: got %h want 8", imem_addr); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out_pc !== 64'h4) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 4", i, out_pc); end
      n_checks++; if (out_instr !== 32'hF8401143) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want f8401143", i, out_instr); end
      n_checks++; if (imem_addr !== 64'h8) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 8", i, imem_addr); end
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_pc !== 64'h8) begin n_fail++; $display("FAIL resume_pc: got %h want 8", out_pc); end
    n_checks++; if (out_instr !== 32'h11111111) begin n_fail++; $display("FAIL resume_instr: got %h want 11111111", out_instr); end
    tick();
    n_checks++; if (out_pc !== 64'hC) begin n_fail++; $display("FAIL resume2_pc: got %h want c", out_pc); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_target = 64'h1E;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_bubble: got %b want 0", out_valid); end
    n_checks++; if (imem_addr !== 64'h1C) begin n_fail++; $display("FAIL redirect_align: got %h want 1c", imem_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_valid_after: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== 64'h1C) begin n_fail++; $display("FAIL redirect_pc: got %h want 1c", out_pc); end
    n_checks++; if (out_instr !== 32'hAA030046) begin n_fail++; $display("FAIL redirect_instr: got %h want aa030046", out_instr); end
    tick(); tick(); tick();
    n_checks++; if (out_pc !== 64'h28) begin n_fail++; $display("FAIL b_pc: got %h want 28", out_pc); end
    n_checks++; if (out_instr !== 32'h17FFFFFD) begin n_fail++; $display("FAIL b_instr: got %h want 17fffffd", out_instr); end
  endtask

  task automatic test_branch();
    tick();
`ifdef FETCH_BRANCH_PREDECODE_EN
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL predecode_valid: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== 64'h1C) begin n_fail++; $display("FAIL predecode_pc: got %h want 1c", out_pc); end
    redirect_valid = 1'b1; redirect_target = 64'h2C;
    tick();
    redirect_valid = 1'b0;
    tick();
`else
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_after_b_valid: got %b want 1", out_valid); end
`endif
    n_checks++; if (out_pc !== 64'h2C) begin n_fail++; $display("FAIL last_pc: got %h want 2c", out_pc); end
    n_checks++; if (out_instr !== 32'h88888888) begin n_fail++; $display("FAIL last_instr: got %h want 88888888", out_instr); end
  endtask

  task automatic test_halt();
    tick();
    n_checks++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b want 1", halt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drained: got %b want 0", out_valid); end
    n_checks++; if (out_pc !== 64'h2C) begin n_fail++; $display("FAIL halt_out_pc: got %h want 2c", out_pc); end
    tick();
    n_checks++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %b want 1", halt); end
    n_checks++; if (imem_addr !== 64'h30) begin n_fail++; $display("FAIL halt_addr: got %h want 30", imem_addr); end
    redirect_valid = 1'b1; redirect_target = 64'h0;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL unhalt: got %b want 0", halt); end
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL unhalt_addr: got %h want 0", imem_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL refetch_valid: got %b want 1", out_valid); end
    n_checks++; if (out_instr !== 32'hF8400142) begin n_fail++; $display("FAIL refetch_instr: got %h want f8400142", out_instr); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    tick();
    n_checks++; if (imem_addr !== 64'h4) begin n_fail++; $display("FAIL pre_reset_addr: got %h want 4", imem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", out_valid); end
    n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL async_halt: got %b want 0", halt); end
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL async_addr: got %h want 0", imem_addr); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL async_instr: got %h want 0", out_instr); end
  endtask

  initial begin
    mem[0]  = 32'hF8400142; mem[1]  = 32'hF8401143;
    mem[2]  = 32'h11111111; mem[3]  = 32'h22222222;
    mem[4]  = 32'h33333333; mem[5]  = 32'h44444444;
    mem[6]  = 32'h55555555; mem[7]  = 32'hAA030046;
    mem[8]  = 32'h66666666; mem[9]  = 32'h77777777;
    mem[10] = 32'h17FFFFFD; mem[11] = 32'h88888888;
    mem[12] = 32'h00000000; mem[13] = 32'h99999999;
    mem[14] = 32'h99999999; mem[15] = 32'h99999999;
    test_reset();
    test_idle();
    test_fetch();
    test_stall();
    test_redirect();
    test_branch();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
